clk_div_sched: RTL and testbench
================================

# clk_div_sched

Round-robin scheduler that shares one programmable countdown engine (the same clock-divider datapath: a free-running counter compared against a 26-bit divisor) among `N_REQ` requesters. Each requester asks for one interval of `div` clock cycles. The block grants the engine to one requester at a time, times the interval, then pulses that requester's `done`. It sits between game/display logic blocks (debounce timers, LED scan, tempo) and replaces per-block private dividers.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 26: divisor width, matching the existing divider.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req` in `N_REQ`: per-requester level request; must stay high until `done` or the request is aborted.
- `div_in` in `N_REQ*W`: packed divisors, requester i at bits `[i*W +: W]`.
- `grant` out `N_REQ`: one-hot (or zero) owner of the engine, registered.
- `done` out `N_REQ`: one-cycle pulse to the owner at end of its interval, registered.
- `busy` out 1: high whenever the state is not IDLE.
- `cnt_out` out `W`: current engine count, for debug only.

## Operation
- States: IDLE, LOAD, COUNT, DONE.
- **IDLE**
  - If `req != 0`, pick the first set bit scanning `last+1, last+2, … last` modulo `N_REQ`.
  - Set `grant` one-hot to the winner and go to LOAD.
  - Otherwise stay in IDLE; `grant = 0`.
- **LOAD**
  - Latch `div_l = div_in[g]`. If `div_in[g] == 0`, latch 1.
  - Clear `cnt` to 0 and go to COUNT.
  - Changes to `div_in` after LOAD are ignored until the next grant.
- **COUNT**
  - Increment `cnt` by 1 each cycle.
  - When `cnt == div_l - 1`, go to DONE.
  - If `req[g]` is sampled low: abort. Go to IDLE, clear `grant`, do not pulse `done`, and set `last = g`.
- **DONE**
  - `done[g] = 1` for exactly this cycle.
  - Next edge: go to IDLE, clear `grant`, set `last = g`.
- Arithmetic: `cnt` is `W` bits and never wraps, because the compare fires at `div_l - 1 <= 2^W - 2`.
- Only the granted requester's `req` is watched after IDLE. Other requests are held pending and never dropped by the block.
- Reset (`rst == 0` at an edge), including mid-interval:
  - state = IDLE, `grant = 0`, `done = 0`, `busy = 0`, `cnt = 0`, `div_l = 0`.
  - `last = N_REQ - 1`, so requester 0 has first priority after reset.
- At most one `grant` bit and at most one `done` bit are high in any cycle.

## Timing
- Edge numbering: edge E0 samples `req` in IDLE.
  - `grant` high after E0; LOAD.
  - After E1: COUNT with `cnt = 0`.
  - After E(1+div): DONE, `done[g] = 1`.
  - After E(2+div): IDLE, `grant = 0`, `done = 0`.
- Request-to-done latency: `div + 1` cycles after the first grant cycle. `grant` is high for `div + 2` cycles.
- Back-to-back: with a pending request, the next grant appears at E(3+div). That is one idle cycle between grants, a fixed 3-cycle overhead per interval.
- `busy` equals `grant != 0`, both registered and with identical timing.
- A `req` that rises on the same edge as a DONE→IDLE transition is considered at the following IDLE edge.
- `rst` overrides all other inputs on the same edge.

## Test plan
- **Reset:** hold `rst = 0` for 3 cycles with all `req` high → `grant`, `done`, `busy`, `cnt_out` all 0. Release → `grant = 0001` on the next edge.
- **Single request:** `req = 0010`, `div_in[1] = 5` → `grant = 0010` for 7 cycles, `done = 0010` for exactly 1 cycle, 6 cycles after `grant` rose. `cnt_out` reaches 4.
- **Round-robin:** `req = 1111` held, all divisors = 3.
  - Grant order is 0, 1, 2, 3, 0.
  - Each `done` is exactly 1 cycle.
  - Spacing between consecutive `done` pulses is 6 cycles.
- **Zero and maximum divisor:**
  - `div_in[0] = 0` → behaves as 1; `done` comes 2 cycles after `grant`.
  - `div_in[0] = 2^26 - 1` (spot-check with `W = 8`, value 255) → `done` comes 256 cycles after `grant`, and `cnt` does not wrap.
- **Abort and divisor change:**
  - Requester 2 is granted with `div = 10`.
  - `div_in[2]` changes to 2 during COUNT, then `req[2]` drops at `cnt = 4` → returns to IDLE with no `done`.
  - With `req = 0101` pending, the next grant goes to requester 0 (round-robin after 2 wraps past 3).
- **Reset mid-interval:** pulse `rst` low for one cycle at `cnt = 3` of a `div = 8` interval → all outputs 0 on the next cycle, no `done`. After release, requester 0 is granted first.

Source files
------------

// File: rtl/clk_div_sched.sv
// Round-robin scheduler sharing one countdown engine among N_REQ requesters.
// Latency: grant one edge after req in IDLE, done div+1 cycles later, then one idle cycle.
// Backpressure: requests wait as held levels; only the owner's req is watched, and dropping it aborts.
module clk_div_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] div_in,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [W-1:0]       cnt_out
);
    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

    state_t           state_q, state_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic [N_REQ-1:0] done_q, done_n;
    logic [W-1:0]     cnt_q, cnt_n;
    logic [W-1:0]     div_l_q, div_l_n;
    logic [LW-1:0]    last_q, last_n;
    logic [LW-1:0]    gidx_q, gidx_n;
    logic [LW-1:0]    pick, cand;
    logic             found;
    logic [W-1:0]     div_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign div_arr[i] = div_in[i*W +: W];
    end

    // Scan starts one past the previous owner so every requester gets a turn.
    always_comb begin
        pick  = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = LW'((int'(last_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        done_n  = '0;
        cnt_n   = cnt_q;
        div_l_n = div_l_q;
        last_n  = last_q;
        gidx_n  = gidx_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gidx_n        = pick;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    state_n       = S_LOAD;
                end
            end
            S_LOAD: begin
                div_l_n = (div_arr[gidx_q] == '0) ? W'(1) : div_arr[gidx_q];
                cnt_n   = '0;
                state_n = S_COUNT;
            end
            S_COUNT: begin
                // Abort wins over completion; cnt holds at div_l-1 so it cannot wrap.
                if (!req[gidx_q]) begin
                    state_n = S_IDLE;
                    grant_n = '0;
                    last_n  = gidx_q;
                end else if (cnt_q == div_l_q - W'(1)) begin
                    state_n        = S_DONE;
                    done_n[gidx_q] = 1'b1;
                end else begin
                    cnt_n = cnt_q + W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                grant_n = '0;
                last_n  = gidx_q;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            div_l_q <= '0;
            last_q  <= LW'(N_REQ - 1);
            gidx_q  <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            done_q  <= done_n;
            cnt_q   <= cnt_n;
            div_l_q <= div_l_n;
            last_q  <= last_n;
            gidx_q  <= gidx_n;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);
    assign cnt_out = cnt_q;
endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench: stimulus queues expected grant/done/release events with cycle stamps,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_clk_div_sched;
    localparam int N = 4;
    localparam int W = 26;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] div_in = '0;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [W-1:0]   cnt_out;

    logic [1:0]  req8 = '0;
    logic [15:0] div8 = 16'h00FF;
    logic [1:0]  grant8, done8;
    logic        busy8;
    logic [7:0]  cnt8;

    clk_div_sched #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .div_in(div_in),
        .grant(grant), .done(done), .busy(busy), .cnt_out(cnt_out)
    );

    clk_div_sched #(.N_REQ(2), .W(8)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .div_in(div8),
        .grant(grant8), .done(done8), .busy(busy8), .cnt_out(cnt8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        byte kind;
        int  idx;
        int  cyc;
    } ev_t;
    ev_t exp_q[$];

    task automatic expect_ev(input byte kind, input int idx, input int c);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic observe(input byte kind, input int idx);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %c req%0d cycle %0d, nothing expected", kind, idx, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.idx != idx || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got %c req%0d cycle %0d expected %c req%0d cycle %0d",
                         kind, idx, cyc, e.kind, e.idx, e.cyc);
            end
        end
    endtask

    // Monitor: G = grant rises, R = grant released, D = done pulse.
    logic [N-1:0] prev_grant = '0;
    always @(negedge clk) begin
        chk("grant_onehot0", longint'($onehot0(grant)), 1);
        chk("done_onehot0", longint'($onehot0(done)), 1);
        chk("busy_eq_grant", longint'(busy), longint'(grant != '0));
        if (grant != prev_grant) begin
            if (prev_grant != '0) observe("R", oh_idx(prev_grant));
            if (grant != '0) observe("G", oh_idx(grant));
        end
        if (done != '0) observe("D", oh_idx(done));
        prev_grant = grant;
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic run_one(input int idx, input int dv);
        int now, eff;
        now = cyc;
        eff = (dv == 0) ? 1 : dv;
        div_in[idx*W +: W] = W'(dv);
        req = '0;
        req[idx] = 1'b1;
        expect_ev("G", idx, now + 1);
        expect_ev("D", idx, now + 2 + eff);
        expect_ev("R", idx, now + 3 + eff);
        wait_to(now + 1 + eff);
        chk("cnt_before_done", cnt_out, eff - 1);
        wait_to(now + 2 + eff);
        req = '0;
        wait_to(now + 3 + eff);
    endtask

    initial begin
        int now, g_at, prevc, maxc, wrap;

        // Reset held with every requester asking.
        req = 4'b1111;
        for (int i = 0; i < N; i++) div_in[i*W +: W] = W'(3);
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt_out, 0);

        // Release into round-robin, div 3: period of 6 cycles, order 0,1,2,3,0.
        now = cyc;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_ev("G", k % N, now + 1 + 6*k);
            expect_ev("D", k % N, now + 5 + 6*k);
            expect_ev("R", k % N, now + 6 + 6*k);
        end
        wait_to(now + 25);
        req = 4'b0001;
        wait_to(now + 29);
        req = '0;
        wait_to(now + 30);

        run_one(1, 5);
        run_one(0, 0);

        // Abort with divisor change mid-count, then round-robin resumes past requester 2.
        now = cyc;
        div_in[2*W +: W] = W'(10);
        div_in[0*W +: W] = W'(1);
        req = 4'b0100;
        expect_ev("G", 2, now + 1);
        expect_ev("R", 2, now + 7);
        expect_ev("G", 0, now + 8);
        expect_ev("D", 0, now + 10);
        expect_ev("R", 0, now + 11);
        expect_ev("G", 2, now + 12);
        expect_ev("D", 2, now + 15);
        expect_ev("R", 2, now + 16);
        wait_to(now + 3);
        div_in[2*W +: W] = W'(2);
        wait_to(now + 6);
        chk("abort_cnt", cnt_out, 4);
        req = 4'b0001;
        wait_to(now + 7);
        req = 4'b0101;
        wait_to(now + 10);
        req = 4'b0100;
        wait_to(now + 15);
        req = '0;
        wait_to(now + 16);

        // One-cycle reset in the middle of a div 8 interval.
        now = cyc;
        div_in[1*W +: W] = W'(8);
        req = 4'b0010;
        expect_ev("G", 1, now + 1);
        expect_ev("R", 1, now + 6);
        expect_ev("G", 0, now + 7);
        expect_ev("D", 0, now + 9);
        expect_ev("R", 0, now + 10);
        wait_to(now + 5);
        chk("mid_cnt", cnt_out, 3);
        rst = 1'b0;
        req = 4'b0011;
        wait_to(now + 6);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", cnt_out, 0);
        rst = 1'b1;
        wait_to(now + 7);
        req = 4'b0001;
        wait_to(now + 9);
        req = '0;
        wait_to(now + 10);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("events_outstanding", exp_q.size(), 0);

        // Maximum divisor on an 8-bit engine: 255 -> done 256 cycles after grant, no wrap.
        req8 = 2'b01;
        for (int i = 0; i < 5 && grant8 == '0; i++) @(negedge clk);
        chk("w8_grant", grant8, 1);
        g_at  = cyc;
        prevc = 0;
        maxc  = 0;
        wrap  = 0;
        for (int i = 0; i < 300 && done8 == '0; i++) begin
            @(negedge clk);
            if (int'(cnt8) < prevc) wrap = 1;
            prevc = int'(cnt8);
            if (prevc > maxc) maxc = prevc;
        end
        chk("w8_done", done8, 1);
        chk("w8_latency", cyc - g_at, 256);
        chk("w8_max_cnt", maxc, 254);
        chk("w8_no_wrap", wrap, 0);
        req8 = '0;
        @(negedge clk);
        chk("w8_release_grant", grant8, 0);
        chk("w8_release_done", done8, 0);
        chk("w8_release_busy", busy8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
